// File: rtl/chain_meter_pkg.sv
// Shared types and constants for the chain delay meter.
// CHAIN_METER_AVG_EN enables four-launch averaging in chain_delay_meter.
package chain_meter_pkg;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_TIMEOUT  = 65535;
  localparam int AVG_LAUNCHES = 4;
  localparam int AVG_SHIFT    = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser bringing the asynchronous chain output into clk.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/chain_delay_meter.sv
// Measures C-element chain delay in clk cycles by launching an edge and counting until it returns.
// Optional macro CHAIN_METER_AVG_EN: average four alternating launches per start.
module chain_delay_meter
  import chain_meter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             chain_in,
  input  logic             chain_out,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state, state_d;
  logic             chain_in_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] count_d;
  logic             timeout_d;
  logic             sync_out;
  logic             match;
  logic             at_limit;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (chain_out),
    .q     (sync_out)
  );

  assign match    = (sync_out == chain_in);
  assign at_limit = (cnt == TMO);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

`ifdef CHAIN_METER_AVG_EN
  localparam int LAUNCH_W = $clog2(AVG_LAUNCHES);

  logic [CNT_W+1:0]    acc, acc_d, acc_sum;
  logic [LAUNCH_W-1:0] launch, launch_d;

  assign acc_sum = acc + {2'b00, cnt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      launch <= '0;
    end else begin
      acc    <= acc_d;
      launch <= launch_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      chain_in <= 1'b0;
      cnt      <= '0;
      count    <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      chain_in <= chain_in_d;
      cnt      <= cnt_d;
      count    <= count_d;
      timeout  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state;
    chain_in_d = chain_in;
    cnt_d      = cnt;
    count_d    = count;
    timeout_d  = timeout;
`ifdef CHAIN_METER_AVG_EN
    acc_d      = acc;
    launch_d   = launch;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
`ifdef CHAIN_METER_AVG_EN
          acc_d    = '0;
          launch_d = '0;
`endif
          // A chain that has not yet settled to our level is drained first.
          if (match) begin
            chain_in_d = ~chain_in;
            state_d    = WAIT;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (match) begin
          chain_in_d = ~chain_in;
          cnt_d      = '0;
          state_d    = WAIT;
        end else if (at_limit) begin
          count_d   = TMO;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (match) begin
`ifdef CHAIN_METER_AVG_EN
          if (launch == LAUNCH_W'(AVG_LAUNCHES - 1)) begin
            count_d   = acc_sum[AVG_SHIFT +: CNT_W];
            timeout_d = 1'b0;
            state_d   = DONE;
          end else begin
            // Relaunch immediately; the edge direction alternates each time.
            acc_d      = acc_sum;
            launch_d   = launch + 1'b1;
            chain_in_d = ~chain_in;
            cnt_d      = '0;
          end
`else
          count_d   = cnt;
          timeout_d = 1'b0;
          state_d   = DONE;
`endif
        end else if (at_limit) begin
          count_d   = TMO;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/chain_delay_meter.md
CHAIN_DELAY_METER -- requirements
Module: chain_delay_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the cycle counter and result.
REQ-002 SHALL have parameter TIMEOUT, default 65535: maximum cycles waited per measurement; legal range 4..2^CNT_W-1.
REQ-003 SHALL have port clk, input, 1: the single system clock.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: measurement request, sampled only in IDLE.
REQ-006 SHALL have port chain_in, output, 1: registered launch level driving the C-element delay chain input.
REQ-007 SHALL have port chain_out, input, 1: chain output, asynchronous to clk.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when a result is valid.
REQ-010 SHALL have port timeout, output, 1: the last result hit TIMEOUT; held until the next done.
REQ-011 SHALL have port count, output, CNT_W: the last measured delay in clk cycles; held until the next done.

Function
REQ-012 SHALL synchronise chain_out through two flops (sync_out); all decisions SHALL use sync_out only.
REQ-013 SHALL implement states IDLE, SETTLE, WAIT, DONE.
REQ-014 IDLE: on start, if sync_out==chain_in then toggle chain_in, clear cnt and go to WAIT; otherwise clear cnt and go to SETTLE.
REQ-015 SETTLE: increment cnt each cycle; on sync_out==chain_in toggle chain_in, clear cnt, go to WAIT; on cnt==TIMEOUT set timeout, count=TIMEOUT, go to DONE.
REQ-016 WAIT: increment cnt each cycle while sync_out!=chain_in; on match latch count=cnt, timeout=0, go to DONE.
REQ-017 WAIT: if cnt reaches TIMEOUT before a match, latch count=TIMEOUT, timeout=1, go to DONE; cnt SHALL never wrap.
REQ-018 Latency convention: a zero-delay chain (chain_out tied to chain_in) SHALL yield count=2, because synchroniser latency is included.
REQ-019 DONE: assert done for exactly one cycle, then return to IDLE.
REQ-020 start while busy SHALL be ignored, not queued; start held high SHALL launch one new measurement each time IDLE is re-entered.
REQ-021 chain_in SHALL change only on launch, so it alternates rising and falling edges between measurements.

Reset
REQ-022 rst_n low SHALL asynchronously force state=IDLE, chain_in=0, cnt=0, count=0, timeout=0, done=0, busy=0, and both synchroniser flops=0.
REQ-023 Reset during SETTLE or WAIT SHALL abandon the measurement with no done pulse; a chain left mid-transition SHALL be absorbed by SETTLE on the next start.

Configuration
REQ-024 Macro CHAIN_METER_AVG_EN: when defined, one start SHALL run four consecutive launches (rising, falling, rising, falling relative to the current level), sum the four cnt values in a CNT_W+2 accumulator, and report count=sum>>2 with a single done.
REQ-025 With CHAIN_METER_AVG_EN defined, a timeout in any launch SHALL abort the remaining launches and report count=TIMEOUT, timeout=1.
REQ-026 Without CHAIN_METER_AVG_EN, each start SHALL perform exactly one launch, and no accumulator SHALL exist.

Structure
REQ-027 Package chain_meter_pkg SHALL hold the state enum typedef, the default CNT_W and TIMEOUT constants, and the averaging launch count (4) and shift (2).
REQ-028 The two-flop synchroniser SHALL be a sub-module named sync2, with asynchronous active-low reset to 0.

Verification
REQ-029 Loopback, chain_out=chain_in, one start: chain_in rises, done after 3 cycles in WAIT, count=2, timeout=0.
REQ-030 Behavioural chain with a 10-cycle delay: count=12; a second start launches a falling edge and also gives count=12.
REQ-031 chain_out stuck at 0, TIMEOUT=20: after launching a rising edge, done with count=20, timeout=1; the next start enters SETTLE and gives timeout=1 again.
REQ-032 start pulsed during WAIT: no extra launch, exactly one done; start held high: back-to-back measurements with alternating chain_in.
REQ-033 rst_n asserted mid-WAIT: all outputs 0 immediately and no done; after release, start with chain_out still 1 goes through SETTLE until chain_out returns to 0.
REQ-034 With CHAIN_METER_AVG_EN and delays of 4, 6, 4, 6 cycles (plus sync): count=7, one done, chain_in back at its starting level.
